// File: rtl/load_store_unit_if.sv
// Pipeline request/response channel plus the single-byte memory port of the
// load/store unit. The unit takes the slave view; the pipeline/memory side takes master.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_sign;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_sign, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_size, req_sign, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Serialises 1..4 byte big-endian loads/stores onto a byte-wide memory port,
// one byte per cycle, then pulses a single-cycle completion response.
module load_store_unit (
  input  logic              clock,
  input  logic              reset_n,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_next;
  logic        we_q;
  logic        sign_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  k;
  logic [31:0] acc;
  logic [31:0] acc_next;
  logic        last;

  assign last     = (k == size_q);
  assign acc_next = {acc[23:0], bus.mem_rdata};

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[8*idx +: 8];
  endfunction

  // Keeps the low 8N bits and fills above with the top data bit only for signed sub-word loads.
  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] size,
                                         input logic sign);
    case (size)
      2'd0:    return {{24{sign & v[7]}},  v[7:0]};
      2'd1:    return {{16{sign & v[15]}}, v[15:0]};
      2'd2:    return {{8{sign & v[23]}},  v[23:0]};
      default: return v;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next     = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_next = ACCESS;
      end
      ACCESS: if (last) state_next = RESP;
      RESP: begin
        bus.resp_valid = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory port signals are registered one cycle ahead, so they depend only on
  // flops and hold their last address/data once the access ends.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      we_q           <= 1'b0;
      sign_q         <= 1'b0;
      size_q         <= 2'd0;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      k              <= 2'd0;
      acc            <= 32'd0;
      bus.resp_rdata <= 32'd0;
      bus.mem_en     <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= 32'd0;
      bus.mem_wdata  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q          <= bus.req_we;
            sign_q        <= bus.req_sign;
            size_q        <= bus.req_size;
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            k             <= 2'd0;
            acc           <= 32'd0;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= bus.req_we;
            bus.mem_addr  <= bus.req_addr;
            bus.mem_wdata <= pick_byte(bus.req_wdata, bus.req_size);
          end
        end
        ACCESS: begin
          acc <= acc_next;
          if (last) begin
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.resp_rdata <= we_q ? 32'd0 : extend(acc_next, size_q, sign_q);
          end else begin
            k             <= k + 2'd1;
            bus.mem_addr  <= addr_q + {30'd0, k + 2'd1};
            bus.mem_wdata <= pick_byte(wdata_q, size_q - k - 2'd1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a 256-byte memory model answers the byte
// port; each vector checks addresses, write data, latency and the load result.
module tb_load_store_unit;

  logic clock = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] mem [256];

  load_store_unit_if bus ();

  load_store_unit dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  always @(posedge clock) begin
    if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic sign, input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_sign  = sign;
    bus.req_wdata = wdata;
  endtask

  // Issue one request from IDLE and follow it through every cycle to completion.
  task automatic run_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic sign, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata);
    int n;
    n = int'(size) + 1;
    drive_req(we, addr, size, sign, wdata);
    check({tag, " ready"}, {31'd0, bus.req_ready}, 32'd1);
    @(negedge clock);
    bus.req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      check({tag, " en"},   {31'd0, bus.mem_en}, 32'd1);
      check({tag, " we"},   {31'd0, bus.mem_we}, {31'd0, we});
      check({tag, " addr"}, bus.mem_addr, addr + 32'(i));
      check({tag, " rv_busy"}, {31'd0, bus.resp_valid}, 32'd0);
      if (we) check({tag, " wdata"}, {24'd0, bus.mem_wdata}, (wdata >> (8 * (n - 1 - i))) & 32'hff);
      @(negedge clock);
    end
    check({tag, " rv"},    {31'd0, bus.resp_valid}, 32'd1);
    check({tag, " en_r"},  {31'd0, bus.mem_en}, 32'd0);
    check({tag, " rdata"}, bus.resp_rdata, exp_rdata);
    @(negedge clock);
    check({tag, " rv_off"}, {31'd0, bus.resp_valid}, 32'd0);
    check({tag, " idle"},   {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    reset_n = 1'b0;
    drive_req(1'b0, 32'd0, 2'd0, 1'b0, 32'd0);
    bus.req_valid = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h12; mem[8'h11] = 8'h34; mem[8'h12] = 8'h56; mem[8'h13] = 8'h78;
    mem[8'h04] = 8'h80; mem[8'h05] = 8'h01; mem[8'h06] = 8'h02; mem[8'h07] = 8'h03;
    mem[8'h08] = 8'h5A; mem[8'h09] = 8'h5A; mem[8'h0A] = 8'h5A; mem[8'h0B] = 8'h5A;
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB; mem[8'h00] = 8'hCC; mem[8'h01] = 8'hDD;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst rv",    {31'd0, bus.resp_valid}, 32'd0);
    check("rst rdata", bus.resp_rdata, 32'd0);
    check("rst en",    {31'd0, bus.mem_en}, 32'd0);
    check("rst we",    {31'd0, bus.mem_we}, 32'd0);
    check("rst addr",  bus.mem_addr, 32'd0);
    check("rst wdata", {24'd0, bus.mem_wdata}, 32'd0);
    reset_n = 1'b1;

    run_req("ldw",     1'b0, 32'h10, 2'd3, 1'b0, 32'd0, 32'h12345678);
    run_req("ldb_s",   1'b0, 32'h04, 2'd0, 1'b1, 32'd0, 32'hFFFFFF80);
    run_req("ldb_u",   1'b0, 32'h04, 2'd0, 1'b0, 32'd0, 32'h00000080);
    run_req("ldh_s",   1'b0, 32'h04, 2'd1, 1'b1, 32'd0, 32'hFFFF8001);
    run_req("ld3_s",   1'b0, 32'h04, 2'd2, 1'b1, 32'd0, 32'hFF800102);
    run_req("ld3_u",   1'b0, 32'h11, 2'd2, 1'b0, 32'd0, 32'h00345678);
    run_req("ldw_s",   1'b0, 32'h04, 2'd3, 1'b1, 32'd0, 32'h80010203);
    run_req("ldw_wrap",1'b0, 32'hFFFFFFFE, 2'd3, 1'b0, 32'd0, 32'hAABBCCDD);

    // resp_rdata holds between responses
    repeat (3) @(negedge clock);
    check("hold rdata", bus.resp_rdata, 32'hAABBCCDD);
    check("hold addr",  bus.mem_addr, 32'h00000001);

    run_req("sth", 1'b1, 32'h08, 2'd1, 1'b0, 32'hAABBCCDD, 32'd0);
    check("sth m08", {24'd0, mem[8'h08]}, 32'hCC);
    check("sth m09", {24'd0, mem[8'h09]}, 32'hDD);
    check("sth m0a", {24'd0, mem[8'h0A]}, 32'h5A);
    check("sth m0b", {24'd0, mem[8'h0B]}, 32'h5A);

    // second request held during busy is ignored until IDLE
    drive_req(1'b0, 32'h10, 2'd0, 1'b0, 32'd0);
    @(negedge clock);
    drive_req(1'b0, 32'h11, 2'd0, 1'b0, 32'd0);
    check("b2b a_addr",  bus.mem_addr, 32'h10);
    check("b2b busy",    {31'd0, bus.req_ready}, 32'd0);
    @(negedge clock);
    check("b2b a_rv",    {31'd0, bus.resp_valid}, 32'd1);
    check("b2b a_rdata", bus.resp_rdata, 32'h12);
    check("b2b resp_rdy",{31'd0, bus.req_ready}, 32'd0);
    check("b2b resp_en", {31'd0, bus.mem_en}, 32'd0);
    @(negedge clock);
    check("b2b idle_rdy",{31'd0, bus.req_ready}, 32'd1);
    check("b2b idle_en", {31'd0, bus.mem_en}, 32'd0);
    @(negedge clock);
    bus.req_valid = 1'b0;
    check("b2b b_en",    {31'd0, bus.mem_en}, 32'd1);
    check("b2b b_addr",  bus.mem_addr, 32'h11);
    @(negedge clock);
    check("b2b b_rv",    {31'd0, bus.resp_valid}, 32'd1);
    check("b2b b_rdata", bus.resp_rdata, 32'h34);
    @(negedge clock);

    // reset mid-store aborts without a response
    mem[8'h00] = 8'hEE; mem[8'h01] = 8'hEE; mem[8'h02] = 8'hEE; mem[8'h03] = 8'hEE;
    drive_req(1'b1, 32'h00, 2'd3, 1'b0, 32'h11223344);
    @(negedge clock);
    bus.req_valid = 1'b0;
    check("rsta k0 wdata", {24'd0, bus.mem_wdata}, 32'h11);
    @(negedge clock);
    check("rsta k1 addr", bus.mem_addr, 32'h01);
    reset_n = 1'b0;
    @(negedge clock);
    check("rsta en",    {31'd0, bus.mem_en}, 32'd0);
    check("rsta ready", {31'd0, bus.req_ready}, 32'd1);
    check("rsta rv",    {31'd0, bus.resp_valid}, 32'd0);
    check("rsta rdata", bus.resp_rdata, 32'd0);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (bus.resp_valid || bus.mem_en) seen++;
    end
    check("rsta quiet", 32'(seen), 32'd0);
    check("rsta m00", {24'd0, mem[8'h00]}, 32'h11);
    check("rsta m01", {24'd0, mem[8'h01]}, 32'h22);
    check("rsta m02", {24'd0, mem[8'h02]}, 32'hEE);
    check("rsta m03", {24'd0, mem[8'h03]}, 32'hEE);

    // reset wins over a simultaneous request
    drive_req(1'b0, 32'h10, 2'd3, 1'b0, 32'd0);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    bus.req_valid = 1'b0;
    reset_n = 1'b1;
    check("rstp en",    {31'd0, bus.mem_en}, 32'd0);
    check("rstp ready", {31'd0, bus.req_ready}, 32'd1);
    @(negedge clock);
    check("rstp still", {31'd0, bus.mem_en}, 32'd0);

    run_req("post", 1'b0, 32'h12, 2'd1, 1'b0, 32'd0, 32'h00005678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clock  in  1  sole clock; all state updates on posedge.
REQ-003 reset_n  in  1  synchronous, active-low reset.
REQ-004 req_valid  in  1  pipeline access request present.
REQ-005 req_ready  out  1  unit can accept a request this cycle.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_addr  in  32  byte address of the first (most significant) byte.
REQ-008 req_size  in  2  access length; byte count N = req_size+1 (0 byte, 1 half, 2 three-byte, 3 word).
REQ-009 req_sign  in  1  sign-extend load result when N<4.
REQ-010 req_wdata  in  32  store data, right-aligned (low N bytes used).
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  load result, right-aligned and extended.
REQ-013 mem_en  out  1  byte-port access strobe.
REQ-014 mem_we  out  1  byte-port write strobe, qualified by mem_en.
REQ-015 mem_addr  out  32  byte-port address.
REQ-016 mem_wdata  out  8  byte-port write data.
REQ-017 mem_rdata  in  8  byte-port read data, combinationally valid in the same cycle as mem_addr.

Function
REQ-018 States SHALL be IDLE, ACCESS, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 Handshake: request SHALL be accepted on a posedge with req_valid=1 and req_ready=1, latching we/addr/size/sign/wdata; IDLE->ACCESS with byte counter k=0.
REQ-020 req_valid while not in IDLE SHALL be ignored; nothing is latched.
REQ-021 In ACCESS, each cycle SHALL drive mem_en=1, mem_addr=addr+k (mod 2^32), mem_we=latched we.
REQ-022 Byte order is big-endian: for a store, mem_wdata at k SHALL be wdata byte index N-1-k (byte 0 = bits 7:0).
REQ-023 For a load, each ACCESS cycle SHALL shift mem_rdata into an accumulator at the posedge (acc = {acc[23:0], mem_rdata}).
REQ-024 After k=N-1, the state SHALL go ACCESS->RESP; the next cycle RESP->IDLE.
REQ-025 In RESP, resp_valid SHALL be 1 for exactly one cycle; mem_en and mem_we SHALL be 0.
REQ-026 Latency: ACCESS occupies cycles 1..N after acceptance; resp_valid SHALL be in cycle N+1; the next request can be accepted no earlier than cycle N+2.
REQ-027 Load result: low 8N bits = accumulated bytes; if req_sign=1 and N<4 and bit 8N-1 = 1, the upper bits SHALL be 1, else 0; req_sign SHALL be ignored for N=4.
REQ-028 Store completion SHALL also pulse resp_valid, with resp_rdata=0.
REQ-029 resp_rdata SHALL hold its value until the next resp_valid.
REQ-030 Outside ACCESS, mem_en=0, mem_we=0, and mem_addr/mem_wdata SHALL hold their last values.
REQ-031 There SHALL be no combinational path from req_* inputs to mem_* or resp_* outputs.
REQ-032 Address wrap: addr+k SHALL wrap modulo 2^32 with no error indication.

Reset
REQ-033 A posedge with reset_n=0 SHALL force IDLE, k=0, req_ready=1, resp_valid=0, resp_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-034 Reset in ACCESS or RESP SHALL abort the access with no resp_valid; bytes already written remain written.
REQ-035 Reset SHALL take precedence over a simultaneous req_valid; the request is not accepted.

Verification
REQ-036 Bytes 0x10..0x13 = 12 34 56 78; load word @0x10 -> mem_addr 10,11,12,13 in cycles 1-4; resp_valid in cycle 5 with resp_rdata=0x12345678.
REQ-037 Byte 0x80 @0x04; load byte, sign=1 -> 0xFFFFFF80; sign=0 -> 0x00000080; half load with 0x80,0x01 and sign=1 -> 0xFFFF8001.
REQ-038 Store half wdata=0xAABBCCDD @0x08 -> write 0xCC@08 (cycle 1), 0xDD@09 (cycle 2); resp_valid in cycle 3 with resp_rdata=0; bytes 0x0A onward untouched.
REQ-039 req_valid held high with a second request during busy -> req_ready=0 and no mem activity for the second request until IDLE; second request accepted on the cycle after resp_valid.
REQ-040 reset_n=0 during ACCESS k=1 of a word store @0x00 -> next cycle mem_en=0, req_ready=1, no resp_valid; only bytes 0x00 and 0x01 written.
REQ-041 Load word @0xFFFFFFFE -> mem_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
